// File: rtl/rgbw_pkg.sv
// rtl/rgbw_pkg.sv - shared constants, types and helpers for the RGBW parameter frame
package rgbw_pkg;

  localparam int FRAME_LEN = 8;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

  // Byte positions within the frame; the receiver decodes with the same indices.
  localparam logic [2:0] IDX_SYNC  = 3'd0;
  localparam logic [2:0] IDX_LINT  = 3'd1;
  localparam logic [2:0] IDX_CIDX  = 3'd2;
  localparam logic [2:0] IDX_RED   = 3'd3;
  localparam logic [2:0] IDX_GREEN = 3'd4;
  localparam logic [2:0] IDX_BLUE  = 3'd5;
  localparam logic [2:0] IDX_WHITE = 3'd6;
  localparam logic [2:0] IDX_MODE  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4
  } tx_state_t;

  typedef struct packed {
    logic [7:0] lint;
    logic [7:0] color_idx;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [7:0] white;
    logic [7:0] mode;
  } rgbw_params_t;

  function automatic logic [7:0] frame_byte(input rgbw_params_t p, input logic [2:0] idx,
                                            input logic [7:0] sync);
    logic [7:0] b;
    case (idx)
      IDX_SYNC:  b = sync;
      IDX_LINT:  b = p.lint;
      IDX_CIDX:  b = p.color_idx;
      IDX_RED:   b = p.red;
      IDX_GREEN: b = p.green;
      IDX_BLUE:  b = p.blue;
      IDX_WHITE: b = p.white;
      default:   b = p.mode;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rgbw_frame_tx_shifter.sv
// rtl/rgbw_frame_tx_shifter.sv - one SPI mode-0 byte: sclk/mosi generation with CLK_DIV half-periods
module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       go,
  input  logic       chain,
  input  logic [7:0] data,
  input  logic [7:0] next_data,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic          active;
  logic [HW-1:0] hcnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  logic half_end;
  logic last_bit;

  assign half_end  = active && (hcnt == HALF_LAST);
  assign last_bit  = (bit_cnt == 3'd7);
  assign byte_done = half_end && !sclk && last_bit;
  assign mosi      = shreg[7];

  always_ff @(posedge clk) begin
    if (!reset) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      hcnt    <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (clear) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      hcnt    <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (load) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      hcnt    <= '0;
      bit_cnt <= 3'd0;
      shreg   <= data;
    end else if (go) begin
      active  <= 1'b1;
      sclk    <= 1'b1;
      hcnt    <= '0;
      bit_cnt <= 3'd0;
    end else if (active) begin
      if (!half_end) begin
        hcnt <= hcnt + HW'(1);
      end else begin
        hcnt <= '0;
        if (sclk) begin
          sclk <= 1'b0;
          // The final falling edge presents the following byte's MSB so it is set up ahead of its first rise.
          if (last_bit) shreg <= next_data;
          else          shreg <= {shreg[6:0], 1'b0};
        end else if (last_bit) begin
          bit_cnt <= 3'd0;
          if (chain) sclk <= 1'b1;
          else       active <= 1'b0;
        end else begin
          sclk    <= 1'b1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/rgbw_frame_tx.sv
// rtl/rgbw_frame_tx.sv - 8-byte RGBW parameter frame transmitter over SPI mode 0
module rgbw_frame_tx
  import rgbw_pkg::*;
#(
  parameter int         CLK_DIV    = 2,
  parameter int         GAP_HALVES = 1,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] lint_in,
  input  logic [7:0] color_idx_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] white_in,
  input  logic [7:0] mode_in,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] byte_idx
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam int GAP_CYC = GAP_HALVES * CLK_DIV;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  tx_state_t     state;
  logic [HW-1:0] cnt;
  logic [GW-1:0] gcnt;
  rgbw_params_t  shadow;

  logic       setup_end, gap_end, hold_end, abort_now;
  logic       sh_clear, sh_go, sh_chain, byte_done;
  logic [7:0] next_byte;

  assign setup_end = (state == ST_SETUP) && (cnt == HALF_LAST);
  assign hold_end  = (state == ST_HOLD) && (cnt == HALF_LAST);
  assign gap_end   = (state == ST_GAP) && (gcnt == GAP_LAST);
  assign abort_now = abort && (state != ST_IDLE);

  assign sh_clear = abort_now || hold_end;
  assign sh_go    = setup_end || gap_end;
  assign sh_chain = (GAP_HALVES == 0) && (byte_idx != IDX_MODE);

  // After the mode byte mosi parks low through HOLD.
  always_comb begin
    next_byte = 8'h00;
    if (byte_idx != IDX_MODE) next_byte = frame_byte(shadow, byte_idx + 3'd1, SYNC_BYTE);
  end

  spi_byte_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (sh_clear),
    .load     ((state == ST_IDLE) && start),
    .go       (sh_go),
    .chain    (sh_chain),
    .data     (SYNC_BYTE),
    .next_data(next_byte),
    .sclk     (spi_sclk),
    .mosi     (spi_mosi),
    .byte_done(byte_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      shadow   <= '0;
      spi_cs_n <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= IDX_SYNC;
    end else begin
      done <= 1'b0;
      if (abort_now) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        gcnt     <= '0;
        spi_cs_n <= 1'b1;
        busy     <= 1'b0;
        byte_idx <= IDX_SYNC;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              shadow   <= '{lint: lint_in, color_idx: color_idx_in, red: red_in,
                            green: green_in, blue: blue_in, white: white_in, mode: mode_in};
              state    <= ST_SETUP;
              cnt      <= '0;
              spi_cs_n <= 1'b0;
              busy     <= 1'b1;
              byte_idx <= IDX_SYNC;
            end
          end
          ST_SETUP: begin
            if (setup_end) state <= ST_SHIFT;
            else           cnt <= cnt + HW'(1);
          end
          ST_SHIFT: begin
            if (byte_done) begin
              if (byte_idx == IDX_MODE) begin
                state <= ST_HOLD;
                cnt   <= '0;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                if (GAP_HALVES != 0) begin
                  state <= ST_GAP;
                  gcnt  <= '0;
                end
              end
            end
          end
          ST_GAP: begin
            if (gap_end) state <= ST_SHIFT;
            else         gcnt <= gcnt + GW'(1);
          end
          ST_HOLD: begin
            if (hold_end) begin
              state    <= ST_IDLE;
              cnt      <= '0;
              spi_cs_n <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              byte_idx <= IDX_SYNC;
            end else begin
              cnt <= cnt + HW'(1);
            end
          end
          default: begin
            state    <= ST_IDLE;
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            byte_idx <= IDX_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgbw_frame_tx.sv
// tb/tb_rgbw_frame_tx.sv - self-checking bench for rgbw_frame_tx (default timing and CLK_DIV=1/no-gap)
module tb_rgbw_frame_tx;

  logic        clk;
  logic        reset;
  logic        start_s [2];
  logic        abort_s [2];
  logic [55:0] prm     [2];
  logic        sclk_w  [2];
  logic        mosi_w  [2];
  logic        cs_n_w  [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [2:0]  idx_w   [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int lowlen[2];
  int maxrun_exp[2];

  int prev_cs[2], prev_sclk[2];
  int low_cnt[2], last_low[2], high_cnt[2], last_high[2];
  int rises[2], run[2], max_run[2], frames[2];
  int done_n[2], done_cyc[2];
  int rx_n[2];
  logic [7:0] acc[2];
  logic [7:0] rx[2][8];

  int t0_v[2], base_v[2];
  logic [55:0] cap_v[2];

  rgbw_frame_tx #(.CLK_DIV(2), .GAP_HALVES(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
    .lint_in(prm[0][55:48]), .color_idx_in(prm[0][47:40]), .red_in(prm[0][39:32]),
    .green_in(prm[0][31:24]), .blue_in(prm[0][23:16]), .white_in(prm[0][15:8]),
    .mode_in(prm[0][7:0]),
    .spi_sclk(sclk_w[0]), .spi_mosi(mosi_w[0]), .spi_cs_n(cs_n_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .byte_idx(idx_w[0])
  );

  rgbw_frame_tx #(.CLK_DIV(1), .GAP_HALVES(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
    .lint_in(prm[1][55:48]), .color_idx_in(prm[1][47:40]), .red_in(prm[1][39:32]),
    .green_in(prm[1][31:24]), .blue_in(prm[1][23:16]), .white_in(prm[1][15:8]),
    .mode_in(prm[1][7:0]),
    .spi_sclk(sclk_w[1]), .spi_mosi(mosi_w[1]), .spi_cs_n(cs_n_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .byte_idx(idx_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor: decodes mosi on sclk rising edges and measures cs_n windows.
  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_cs[d] = 1; prev_sclk[d] = 0; low_cnt[d] = 0; last_low[d] = 0;
      high_cnt[d] = 0; last_high[d] = 0; rises[d] = 0; run[d] = 0; max_run[d] = 0;
      frames[d] = 0; done_n[d] = 0; done_cyc[d] = 0; rx_n[d] = 0; acc[d] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (cs_n_w[d] === 1'b0) begin
          if (prev_cs[d] != 0) begin
            last_high[d] = high_cnt[d]; high_cnt[d] = 0; low_cnt[d] = 0;
            rises[d] = 0; rx_n[d] = 0; run[d] = 0; max_run[d] = 0; frames[d]++;
          end
          low_cnt[d]++;
          if (sclk_w[d] === 1'b1 && prev_sclk[d] == 0) begin
            acc[d] = {acc[d][6:0], mosi_w[d]};
            rises[d]++;
            if (rises[d] % 8 == 0 && rx_n[d] < 8) begin
              rx[d][rx_n[d]] = acc[d];
              rx_n[d]++;
            end
          end
          if (sclk_w[d] !== 1'b1 && rises[d] < 64) begin
            run[d]++;
            if (run[d] > max_run[d]) max_run[d] = run[d];
          end else begin
            run[d] = 0;
          end
          prev_cs[d] = 0;
        end else begin
          if (prev_cs[d] == 0) last_low[d] = low_cnt[d];
          high_cnt[d]++;
          prev_cs[d] = 1;
        end
        if (done_w[d] === 1'b1) begin
          done_n[d]++;
          done_cyc[d] = cyc;
        end
        prev_sclk[d] = (sclk_w[d] === 1'b1) ? 1 : 0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] ovec(input int d);
    return {cs_n_w[d], sclk_w[d], mosi_w[d], busy_w[d], done_w[d], idx_w[d]};
  endfunction

  task automatic rand_params(input int d);
    prm[d][55:32] = 24'($urandom());
    prm[d][31:0]  = $urandom();
  endtask

  task automatic pulse_start(input int d);
    cap_v[d]  = prm[d];
    t0_v[d]   = cyc;
    base_v[d] = done_n[d];
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
  endtask

  // Waits for done, then checks the frame against the expected byte list and timing.
  task automatic finish_frame(input int d, input string tag);
    logic [7:0] exp_b;
    int k;
    for (k = 0; k < 3000 && done_n[d] == base_v[d]; k++) tick();
    chk({tag, "_done_seen"}, (done_n[d] != base_v[d]) ? 1 : 0, 1);
    chk({tag, "_done_lat"}, done_cyc[d] - t0_v[d], lowlen[d] + 1);
    chk({tag, "_cs_low"}, last_low[d], lowlen[d]);
    chk({tag, "_rises"}, rises[d], 64);
    chk({tag, "_max_idle"}, max_run[d], maxrun_exp[d]);
    chk({tag, "_end_vec"}, ovec(d), 8'h88);
    for (int b = 0; b < 8; b++) begin
      exp_b = (b == 0) ? 8'h55 : cap_v[d][63-8*b -: 8];
      chk($sformatf("%s_byte%0d", tag, b), (b < rx_n[d]) ? rx[d][b] : 9'h1FF, exp_b);
    end
  endtask

  initial begin
    int fr;
    lowlen[0] = 2 * (2 + 128 + 7 * 1);
    lowlen[1] = 1 * (2 + 128 + 7 * 0);
    maxrun_exp[0] = 2 * (1 + 1);
    maxrun_exp[1] = 1 * (1 + 0);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b1;
      abort_s[d] = 1'b0;
      prm[d] = 56'h0;
    end

    // Reset dominates a held start.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_vec0_c%0d", i), ovec(0), 8'h80);
      chk($sformatf("rst_vec1_c%0d", i), ovec(1), 8'h80);
    end
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    reset = 1'b1;
    repeat (20) tick();
    chk("post_rst_frames0", frames[0], 0);
    chk("post_rst_frames1", frames[1], 0);
    chk("post_rst_vec0", ovec(0), 8'h80);

    // Directed frame with the documented values.
    prm[0] = {8'hA0, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01};
    pulse_start(0);
    chk("setup_vec", ovec(0), 8'h10);
    finish_frame(0, "dir");
    repeat (3) tick();
    chk("dir_single_done", done_n[0] - base_v[0], 1);

    // Inputs change after acceptance; a mid-frame start is dropped.
    rand_params(0);
    pulse_start(0);
    prm[0] = '1;
    repeat (100) tick();
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    fr = frames[0];
    finish_frame(0, "capt");
    repeat (20) tick();
    chk("capt_no_queue", frames[0], fr);
    chk("capt_one_done", done_n[0] - base_v[0], 1);

    // Abort in the middle of byte 4.
    rand_params(0);
    pulse_start(0);
    begin
      int k;
      for (k = 0; k < 2000 && rises[0] < 36; k++) tick();
    end
    chk("abort_reached", (rises[0] >= 36) ? 1 : 0, 1);
    chk("abort_idx", idx_w[0], 4);
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    chk("abort_vec", ovec(0), 8'h80);
    repeat (10) tick();
    chk("abort_no_done", done_n[0], base_v[0]);
    abort_s[0] = 1'b1;
    repeat (3) tick();
    abort_s[0] = 1'b0;
    chk("idle_abort_vec", ovec(0), 8'h80);
    rand_params(0);
    pulse_start(0);
    finish_frame(0, "after_abort");

    // Fast configuration with randomized payloads.
    for (int i = 0; i < 4; i++) begin
      rand_params(1);
      pulse_start(1);
      finish_frame(1, $sformatf("fast%0d", i));
      repeat ($urandom_range(4, 1)) tick();
    end

    // start and abort together while idle: start wins.
    rand_params(1);
    abort_s[1] = 1'b1;
    pulse_start(1);
    abort_s[1] = 1'b0;
    finish_frame(1, "st_ab");

    // Reset in mid-frame ends it without done.
    repeat (2) tick();
    rand_params(1);
    pulse_start(1);
    repeat (30) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_vec", ovec(1), 8'h80);
    repeat (5) tick();
    chk("midrst_no_done", done_n[1], base_v[1]);

    // Back-to-back frames started in the done cycle.
    for (int d = 0; d < 2; d++) begin
      rand_params(d);
      pulse_start(d);
      finish_frame(d, $sformatf("b2b%0d_a", d));
      rand_params(d);
      pulse_start(d);
      finish_frame(d, $sformatf("b2b%0d_b", d));
      chk($sformatf("b2b%0d_cs_high", d), last_high[d], 1);
      repeat (3) tick();
    end

    // A few more randomized default-timing frames.
    for (int i = 0; i < 2; i++) begin
      rand_params(0);
      pulse_start(0);
      finish_frame(0, $sformatf("rnd%0d", i));
      repeat ($urandom_range(5, 1)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rgbw_frame_tx.md
Name: rgbw_frame_tx

Overview:
- SPI-master frame transmitter for the RGBW controller's 8-byte parameter frame.
- Frame order: sync 0x55, lint, colorIdx, red, green, blue, white, mode.
- Host logic or a test/loopback path loads seven parameter bytes and pulses start; the block serializes the frame MSB-first in SPI mode 0 with one chip-select window per frame.
- A receiving controller can reproduce the latched parameter set from this frame.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range >=1.
- GAP_HALVES, 1: idle SCLK half-periods inserted between bytes, with CS held low; 0 allowed.
- SYNC_BYTE, 8'h55: first byte of every frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle request; accepted only when busy=0
- abort  in  1  terminates a frame in progress
- lint_in  in  8  lint byte
- color_idx_in  in  8  colorIdx byte
- red_in  in  8  red byte
- green_in  in  8  green byte
- blue_in  in  8  blue byte
- white_in  in  8  white byte
- mode_in  in  8  mode byte
- spi_sclk  out  1  serial clock; idles low
- spi_mosi  out  1  serial data, MSB first
- spi_cs_n  out  1  frame select, active low
- busy  out  1  high from the cycle after start acceptance until the frame ends or aborts
- done  out  1  one-cycle pulse on normal completion
- byte_idx  out  3  index of the byte currently shifting, 0=sync through 7=mode

Behaviour:
- Reset: clk rising edge with reset=0. Values: spi_sclk=0, spi_mosi=0, spi_cs_n=1, busy=0, done=0, byte_idx=0, state IDLE, shadow registers 0. Reset wins over start and abort in the same cycle. Reset mid-frame ends the frame on the next edge with no done.
- Acceptance: start sampled in cycle T with busy=0 (the done cycle counts as busy=0).
  - All seven inputs are captured into shadow registers at T.
  - Input changes after T do not affect the frame in flight.
  - start while busy=1 is ignored and not queued.
- States: IDLE -> SETUP -> SHIFT -> (GAP -> SHIFT)* -> HOLD -> IDLE.
- Half-period counter: counts 0..CLK_DIV-1; the state or phase advances on terminal count.
- SETUP (CLK_DIV cycles, from T+1): cs_n=0, sclk=0, mosi=SYNC_BYTE[7], busy=1.
- SHIFT: 16 half-periods per byte.
  - sclk rises, then falls.
  - Each falling edge except the last of the byte drives the next bit onto mosi.
  - mosi is stable for the full high phase; the receiver samples on the rising edge.
- Byte end: after the 8th falling edge, byte_idx increments.
  - If byte_idx was <7 and GAP_HALVES>0: GAP for GAP_HALVES*CLK_DIV cycles, sclk=0, mosi=bit7 of the next byte.
  - If GAP_HALVES=0: next byte's bit7 is driven on that falling edge; no extra delay.
- HOLD: after byte 7, CLK_DIV cycles with cs_n=0, sclk=0.
- Completion: next cycle cs_n=1, mosi=0, busy=0, done=1 (one cycle); byte_idx returns to 0.
- cs_n low duration: exactly CLK_DIV*(2 + 128 + 7*GAP_HALVES) cycles, i.e. 274 with defaults.
- Abort while busy=1: next cycle cs_n=1, sclk=0, mosi=0, busy=0, byte_idx=0, done=0, state IDLE. Abort while idle has no effect.
- Same-cycle start and abort while busy=0: start wins.
- Counters saturate nowhere and wrap nowhere.
  - Bit counter is 3 bits; byte_idx is 3 bits; terminal values are decoded explicitly.
  - Half-period counter width is $clog2(CLK_DIV+1).
  - GAP counter width is sized from GAP_HALVES*CLK_DIV.

Decomposition:
- Shared package rgbw_pkg holds:
  - FRAME_LEN=8 and SYNC_BYTE default 8'h55.
  - Byte-index constants IDX_SYNC=0, IDX_LINT=1, IDX_CIDX=2, IDX_RED=3, IDX_GREEN=4, IDX_BLUE=5, IDX_WHITE=6, IDX_MODE=7, also used by the receiver.
  - FSM state encoding for this block.
- One sub-module, spi_byte_shifter.
  - Role: loads a byte, generates sclk/mosi with CLK_DIV timing, and pulses byte_done.
  - The top level owns cs_n, frame sequencing, gaps, abort and shadow registers.

Test Plan:
1. Reset held low for 3 cycles with start=1 -> cs_n=1, sclk=0, mosi=0, busy=0, done=0, byte_idx=0 throughout; no frame after reset release until a new start.
2. Defaults, start with lint=8'hA0, cidx=8'h03, R=8'h12, G=8'h34, B=8'h56, W=8'h78, mode=8'h01 -> monitor sampling mosi on sclk rising edges decodes 55 A0 03 12 34 56 78 01; exactly 64 rising edges; cs_n low 274 cycles; done one cycle at T+275.
3. Inputs changed to 8'hFF one cycle after start -> transmitted bytes remain the captured values; second start mid-frame is ignored and the cs_n low window is unchanged.
4. abort asserted during byte_idx=4, bit 3 -> next cycle cs_n=1, busy=0, sclk=0, no done; a following start sends a complete, correct frame.
5. CLK_DIV=1, GAP_HALVES=0 -> sclk toggles every cycle, no idle half-periods between bytes, cs_n low exactly 130 cycles, bytes decode correctly.
6. start asserted in the done cycle -> new frame accepted; cs_n high exactly 1 cycle between frames; both frames decode correctly.
